// File: rtl/sseg_pkg.sv
// -----------------------------------------------------------------------------
// sseg_pkg
// Shared definitions for the multiplexed seven-segment driver and its
// receive-side scan decoder.
//   SEG_CODE      : 16-entry table, hex digit -> active-low g..a pattern
//   AN_BLANK      : anode word with every digit disabled
//   seg_to_nibble : reverse lookup, pattern -> {valid, nibble}
// -----------------------------------------------------------------------------
package sseg_pkg;

    localparam logic [7:0] AN_BLANK = 8'hFF;

    // Index = hex value; bit6 = g ... bit0 = a, 0 = segment lit.
    localparam logic [6:0] SEG_CODE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Returns {1'b1, nibble} on a table hit, 5'b0 for any other pattern.
    function automatic logic [4:0] seg_to_nibble(input logic [6:0] seg);
        logic [4:0] result;
        result = 5'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_CODE[i]) begin
                result = {1'b1, 4'(i)};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sseg_seg_decode.sv
// -----------------------------------------------------------------------------
// sseg_seg_decode
// Combinational cathode decoder: active-low g..a pattern to hex nibble.
//   seg    in  7  cathode pattern, bit6 = g ... bit0 = a, active-low
//   valid  out 1  pattern is one of the 16 hex glyphs
//   nibble out 4  decoded value (0 when not valid)
// -----------------------------------------------------------------------------
module sseg_seg_decode
    import sseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] nibble
);

    assign {valid, nibble} = seg_to_nibble(seg);

endmodule

// File: rtl/sseg_scan_decoder.sv
// -----------------------------------------------------------------------------
// sseg_scan_decoder
// Watches the scanned anode/cathode lines of an 8-digit multiplexed display,
// decodes every digit back to a nibble plus decimal point, reassembles whole
// frames and publishes the 32-bit value once MATCH_FRAMES identical frames
// have been seen in a row.
//   CLK        in   1   clock, rising edge
//   RST        in   1   synchronous reset, active-high
//   SSEG_AN    in   8   anodes, active-low, bit7 = leftmost = VALUE[31:28]
//   SSEG_CA    in   8   cathodes, active-low, bit7 = dp, bits6:0 = g..a
//   VALUE      out  32  last published value
//   DP         out  8   last published decimal points, 1 = lit
//   VALUE_UPD  out  1   pulse: VALUE/DP (re)published
//   DECODE_ERR out  1   pulse: unknown glyph or more than one anode low
//   FRAME_ERR  out  1   pulse: partial frame dropped after timeout
// -----------------------------------------------------------------------------
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int MATCH_FRAMES   = 2,
    parameter int TIMEOUT_CYCLES = 1048576
)(
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  SSEG_AN,
    input  logic [7:0]  SSEG_CA,
    output logic [31:0] VALUE,
    output logic [7:0]  DP,
    output logic        VALUE_UPD,
    output logic        DECODE_ERR,
    output logic        FRAME_ERR
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int MW = $clog2(MATCH_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Registered pin copies and settle tracking
    logic [7:0]    an_q, ca_q, an_prev;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] timeout_cnt;

    // Frame assembly and comparison state
    logic [7:0]    mask;
    logic [31:0]   frame_val, prev_val;
    logic [7:0]    frame_dp,  prev_dp;
    logic          prev_valid;
    logic [MW-1:0] match_cnt;

    // Decoder
    logic       seg_valid;
    logic [3:0] seg_nib;

    sseg_seg_decode u_seg_decode (
        .seg    (ca_q[6:0]),
        .valid  (seg_valid),
        .nibble (seg_nib)
    );

    // Anode classification
    logic [7:0] an_low;
    logic       an_changed, one_low, blank, illegal;
    logic [2:0] digit_idx;

    assign an_low     = ~an_q;
    assign an_changed = (an_q != an_prev);
    assign one_low    = (an_low != 8'h00) && ((an_low & (an_low - 8'h01)) == 8'h00);
    assign blank      = (an_q == AN_BLANK);
    assign illegal    = !one_low && !blank;

    // NOTE: always_comb gives every output a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        digit_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!an_q[i]) begin
                digit_idx = 3'(i);
            end
        end
    end

    // settle_cnt counts stable cycles after the change cycle, so the sample
    // lands SETTLE_CYCLES cycles after the new anode word first appears.
    // It saturates at SETTLE_CYCLES, which blocks a second sample per dwell.
    logic settle_hit, sample, dec_err, timeout_hit, discard;

    assign settle_hit  = !an_changed && (settle_cnt == SW'(SETTLE_CYCLES - 1));
    assign sample      = settle_hit && one_low && seg_valid;
    assign dec_err     = settle_hit && (illegal || (one_low && !seg_valid));
    assign timeout_hit = !sample && (mask != 8'h00)
                         && (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign discard     = dec_err || timeout_hit;

    // The frame as it stands including this cycle's sample, so completion and
    // comparison happen in the same cycle as the last digit.
    logic [31:0]   cur_val;
    logic [7:0]    cur_dp, mask_upd;
    logic          complete, frame_eq, publish;
    logic [MW-1:0] match_next;

    always_comb begin
        cur_val = frame_val;
        cur_dp  = frame_dp;
        cur_val[{digit_idx, 2'b00} +: 4] = seg_nib;
        cur_dp[digit_idx]                = ~ca_q[7];
    end

    assign mask_upd = mask | (8'b1 << digit_idx);
    assign complete = sample && (mask_upd == 8'hFF);
    assign frame_eq = prev_valid && (cur_val == prev_val) && (cur_dp == prev_dp);

    always_comb begin
        if (frame_eq) begin
            match_next = (match_cnt == MW'(MATCH_FRAMES)) ? match_cnt : match_cnt + 1'b1;
        end else begin
            match_next = MW'(1);
        end
    end

    assign publish = complete && (match_next >= MW'(MATCH_FRAMES));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            an_q        <= AN_BLANK;
            ca_q        <= 8'hFF;
            an_prev     <= AN_BLANK;
            settle_cnt  <= '0;
            timeout_cnt <= '0;
            mask        <= 8'h00;
            prev_valid  <= 1'b0;
            match_cnt   <= '0;
            VALUE       <= 32'h0;
            DP          <= 8'h00;
            VALUE_UPD   <= 1'b0;
            DECODE_ERR  <= 1'b0;
            FRAME_ERR   <= 1'b0;
        end else begin
            an_q    <= SSEG_AN;
            ca_q    <= SSEG_CA;
            an_prev <= an_q;

            if (an_changed) begin
                settle_cnt <= '0;
            end else if (settle_cnt != SW'(SETTLE_CYCLES)) begin
                settle_cnt <= settle_cnt + 1'b1;
            end

            // Blank dwell still ages the frame; an idle display saturates.
            if (sample) begin
                timeout_cnt <= '0;
            end else if (timeout_cnt != TW'(TIMEOUT_CYCLES)) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end

            VALUE_UPD  <= publish && !discard;
            DECODE_ERR <= dec_err;
            FRAME_ERR  <= timeout_hit;

            // Errors take priority over completion.
            if (discard) begin
                mask       <= 8'h00;
                match_cnt  <= '0;
                prev_valid <= 1'b0;
            end else if (complete) begin
                mask       <= 8'h00;
                match_cnt  <= match_next;
                prev_valid <= 1'b1;
                if (publish) begin
                    VALUE <= cur_val;
                    DP    <= cur_dp;
                end
            end else if (sample) begin
                mask <= mask_upd;
            end
        end
    end

    // NOTE: frame slots and the previous-frame copy carry no reset; mask and
    // prev_valid already qualify them, so their power-up contents never escape.
    always_ff @(posedge CLK) begin
        if (sample && !discard) begin
            frame_val <= cur_val;
            frame_dp  <= cur_dp;
        end
        if (complete && !discard) begin
            prev_val <= cur_val;
            prev_dp  <= cur_dp;
        end
    end

endmodule
